mem_read_demux: RTL and testbench
=================================

# mem_read_demux

Return-path companion to the pipeline's operand/address multiplexers for the single-ported unified instruction/data memory. Time-slices the memory port between instruction fetch and the MEM stage, routes synchronous read data back to the requesting stage and holds it. Sits between the IF/MEM stages and the unified memory in the pipelined RV32I core.

## Interface
Parameters:
- N, 32, data and address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  N  fetch byte address.
- mem_rd  in  1  MEM-stage load request.
- mem_wr  in  1  MEM-stage store request; wins if both set.
- mem_addr  in  N  MEM-stage byte address.
- mem_wdata  in  N  store data, passed through.
- mem_funct3  in  3  load type (LB/LH/LW/LBU/LHU).
- ram_addr  out  N  memory address.
- ram_we  out  1  memory write enable.
- ram_wdata  out  N  memory write data.
- ram_rdata  in  N  memory read data, valid one cycle after address.
- if_slot  out  1  high in fetch slot; IF may only advance here.
- mem_slot  out  1  high in data slot; MEM may only issue here.
- inst_out  out  N  last fetched instruction, held.
- inst_valid  out  1  one-cycle pulse, new inst_out.
- load_data  out  N  last load result, held.
- load_valid  out  1  one-cycle pulse, new load_data.

## Operation
- Phase register toggles every cycle: phase 0 = data slot, phase 1 = fetch slot. if_slot = phase, mem_slot = ~phase.
- Data slot: mem_wr -> ram_addr = mem_addr, ram_we = 1, ram_wdata = mem_wdata, no read tag. Else mem_rd -> ram_addr = mem_addr, ram_we = 0, tag = DATA; funct3 and addr[1:0] latched.
- Fetch slot: if_req -> ram_addr = if_addr, ram_we = 0, tag = FETCH.
- No request in slot -> ram_addr = 0, ram_we = 0, tag = NONE.
- Requests presented outside their slot are ignored (not queued); stages hold them until their slot.
- Cycle after tag FETCH: inst_out <= ram_rdata, inst_valid = 1. Cycle after tag DATA: load_data <= extracted word, load_valid = 1. Never both in one cycle.
- Extraction: byte selected by addr[1:0], halfword by addr[1] (addr[0] ignored); LB/LH sign-extend, LBU/LHU zero-extend; LW and funct3 3/6/7 return raw word.

## Timing
- Reset values: phase = 0, tag = NONE, inst_out = 0, load_data = 0, inst_valid = 0, load_valid = 0, ram_we = 0, ram_addr = 0. First post-reset cycle is a data slot.
- ram_* outputs combinational from phase and requests.
- Read latency: request cycle T -> valid pulse and new held data visible at T+1 (registered).
- Back-to-back: data read at T, fetch at T+1 -> load_valid at T+1, inst_valid at T+2.
- Reset asserted while a tag is pending: tag cleared, no valid pulse on the following cycle; phase returns to 0.
- Store never produces a valid pulse.

## Configuration
- LOAD_EXTRACT_EN defined: sub-word extraction and sign/zero extension as above.
- Undefined: load_data <= ram_rdata unmodified for every funct3; funct3 and addr[1:0] are not latched.

## Structure
- defines.v holds the funct3 load encodings (LB=0, LH=1, LW=2, LBU=4, LHU=5) and tag encodings (NONE=0, FETCH=1, DATA=2).
- One sub-module: load_extractor (combinational, word + funct3 + addr[1:0] -> N-bit result), instantiated only under LOAD_EXTRACT_EN.

## Test plan
- Reset, then if_req=1, if_addr=0x10 held: ram_addr=0x10 only on phase-1 cycles; next cycle inst_out=ram_rdata (0x00500093), inst_valid pulse.
- Data slot, mem_rd=1, mem_addr=0x203, funct3=LB, ram_rdata=0x80FF7F01 -> load_data=0xFFFFFF80; same with LBU -> 0x00000080.
- Data slot, LH, addr=0x202, rdata=0x8001ABCD -> 0xFFFF8001; LHU -> 0x00008001; LW -> 0x8001ABCD.
- Data slot, mem_wr=1 and mem_rd=1, addr=0x40, wdata=0xDEADBEEF -> ram_we=1, ram_wdata=0xDEADBEEF, no load_valid next cycle.
- Data read at T, fetch at T+1 -> load_valid only at T+1, inst_valid only at T+2, held values stable afterward.
- Fetch issued, rst high next cycle -> no inst_valid, inst_out=0, phase=0; with LOAD_EXTRACT_EN undefined, LB at 0x203 returns raw 0x80FF7F01.

Source files
------------

// File: rtl/mem_read_demux_pkg.sv
// mem_read_demux_pkg: shared read-tag and load funct3 encodings
package mem_read_demux_pkg;
    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DATA  = 2'd2
    } tag_t;
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
endpackage

// File: rtl/mem_read_demux_if.sv
// mem_read_demux_if: stage request, unified memory and return-path signals
interface mem_read_demux_if #(parameter int N = 32);
    logic         if_req;
    logic [N-1:0] if_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [2:0]   mem_funct3;
    logic [N-1:0] ram_addr;
    logic         ram_we;
    logic [N-1:0] ram_wdata;
    logic [N-1:0] ram_rdata;
    logic         if_slot;
    logic         mem_slot;
    logic [N-1:0] inst_out;
    logic         inst_valid;
    logic [N-1:0] load_data;
    logic         load_valid;
    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3, ram_rdata,
        input  ram_addr, ram_we, ram_wdata, if_slot, mem_slot, inst_out, inst_valid, load_data, load_valid
    );
    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3, ram_rdata,
        output ram_addr, ram_we, ram_wdata, if_slot, mem_slot, inst_out, inst_valid, load_data, load_valid
    );
endinterface

// File: rtl/mem_read_demux_load_extractor.sv
// load_extractor: selects byte/halfword from a read word and sign/zero extends it
module load_extractor
    import mem_read_demux_pkg::*;
#(parameter int N = 32) (
    input  logic [N-1:0] word,
    input  logic [2:0]   funct3,
    input  logic [1:0]   addr_lo,
    output logic [N-1:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = word[{addr_lo, 3'b000} +: 8];
    assign h = addr_lo[1] ? word[16 +: 16] : word[0 +: 16];
    // LW and undefined encodings fall through to the raw word
    always_comb begin
        result = funct3 == F3_LB  ? {{(N-8){b[7]}}, b} :
                 funct3 == F3_LH  ? {{(N-16){h[15]}}, h} :
                 funct3 == F3_LBU ? {{(N-8){1'b0}}, b} :
                 funct3 == F3_LHU ? {{(N-16){1'b0}}, h} : word;
    end
endmodule

// File: rtl/mem_read_demux.sv
// mem_read_demux: time-slices the unified memory between fetch and MEM, routes read data back
// Optional feature macro: LOAD_EXTRACT_EN (sub-word load extraction; raw word when undefined)
module mem_read_demux
    import mem_read_demux_pkg::*;
#(parameter int N = 32) (
    input logic clk,
    input logic rst,
    mem_read_demux_if.slave bus
);
    logic         phase;
    tag_t         tag;
    tag_t         next_tag;
    logic [N-1:0] inst_hold;
    logic [N-1:0] load_hold;
    logic [N-1:0] ext;
    logic         fetch_hit;
    logic         data_hit;

    // Read data is bypassed in the return cycle so the pulse and its data appear together;
    // reset suppresses a pending return
    assign fetch_hit      = tag == TAG_FETCH && !rst;
    assign data_hit       = tag == TAG_DATA && !rst;
    assign bus.if_slot    = phase;
    assign bus.mem_slot   = ~phase;
    assign bus.inst_valid = fetch_hit;
    assign bus.load_valid = data_hit;
    assign bus.inst_out   = fetch_hit ? bus.ram_rdata : inst_hold;
    assign bus.load_data  = data_hit ? ext : load_hold;

`ifdef LOAD_EXTRACT_EN
    logic [2:0] funct3_q;
    logic [1:0] addr_lo_q;

    // Remember load type and byte offset of the read issued in the data slot
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
        end else if (!phase && !bus.mem_wr && bus.mem_rd) begin
            funct3_q  <= bus.mem_funct3;
            addr_lo_q <= bus.mem_addr[1:0];
        end
    end

    load_extractor #(.N(N)) u_extract (
        .word    (bus.ram_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .result  (ext)
    );
`else
    assign ext = bus.ram_rdata;
`endif

    // Slot arbitration: store beats load in the data slot, fetch owns the other slot
    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = bus.mem_wdata;
        next_tag      = TAG_NONE;
        if (!rst && !phase) begin
            if (bus.mem_wr) begin
                bus.ram_addr = bus.mem_addr;
                bus.ram_we   = 1'b1;
            end else if (bus.mem_rd) begin
                bus.ram_addr = bus.mem_addr;
                next_tag     = TAG_DATA;
            end
        end else if (!rst && bus.if_req) begin
            bus.ram_addr = bus.if_addr;
            next_tag     = TAG_FETCH;
        end
    end

    // Phase toggle, pending tag and held return values
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= 1'b0;
            tag       <= TAG_NONE;
            inst_hold <= '0;
            load_hold <= '0;
        end else begin
            phase <= ~phase;
            tag   <= next_tag;
            if (tag == TAG_FETCH) inst_hold <= bus.ram_rdata;
            if (tag == TAG_DATA) load_hold <= ext;
        end
    end
endmodule

// File: tb/tb_mem_read_demux.sv
// tb_mem_read_demux: directed table-driven check of slot arbitration and read return
module tb_mem_read_demux;
    import mem_read_demux_pkg::*;

    typedef struct {
        string       name;
        bit          fetch;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [31:0] ext;
        logic [31:0] raw;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    bit   ph = 1'b0;
    vec_t v[12];

    mem_read_demux_if #(.N(32)) bus ();
    mem_read_demux #(.N(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ph = ~ph;
    endtask

    task automatic idle();
        bus.if_req = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
    endtask

    task automatic apply(input vec_t t);
        logic [31:0] exp;
`ifdef LOAD_EXTRACT_EN
        exp = t.ext;
`else
        exp = t.raw;
`endif
        idle();
        while (ph != t.fetch) step();
        bus.if_req     = t.fetch;
        bus.if_addr    = t.addr;
        bus.mem_rd     = t.rd;
        bus.mem_wr     = t.wr;
        bus.mem_addr   = t.addr;
        bus.mem_wdata  = t.wdata;
        bus.mem_funct3 = t.f3;
        #1;
        chk({t.name, " ram_addr"}, bus.ram_addr, t.addr);
        chk({t.name, " ram_we"}, {31'd0, bus.ram_we}, {31'd0, t.wr});
        if (t.wr) chk({t.name, " ram_wdata"}, bus.ram_wdata, t.wdata);
        step();
        idle();
        bus.ram_rdata = t.rdata;
        #1;
        chk({t.name, " inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, t.fetch});
        chk({t.name, " load_valid"}, {31'd0, bus.load_valid}, {31'd0, t.rd & ~t.wr});
        if (t.fetch) chk({t.name, " inst_out"}, bus.inst_out, t.rdata);
        else if (!t.wr) chk({t.name, " load_data"}, bus.load_data, exp);
    endtask

    initial begin
        v[0]  = '{"lb203",   0, 1, 0, 32'h203, 0, F3_LB,  32'h80FF7F01, 32'hFFFFFF80, 32'h80FF7F01};
        v[1]  = '{"lbu203",  0, 1, 0, 32'h203, 0, F3_LBU, 32'h80FF7F01, 32'h00000080, 32'h80FF7F01};
        v[2]  = '{"lh202",   0, 1, 0, 32'h202, 0, F3_LH,  32'h8001ABCD, 32'hFFFF8001, 32'h8001ABCD};
        v[3]  = '{"lhu202",  0, 1, 0, 32'h202, 0, F3_LHU, 32'h8001ABCD, 32'h00008001, 32'h8001ABCD};
        v[4]  = '{"lw200",   0, 1, 0, 32'h200, 0, F3_LW,  32'h8001ABCD, 32'h8001ABCD, 32'h8001ABCD};
        v[5]  = '{"lb200",   0, 1, 0, 32'h200, 0, F3_LB,  32'h80FF7F01, 32'h00000001, 32'h80FF7F01};
        v[6]  = '{"lh201",   0, 1, 0, 32'h201, 0, F3_LH,  32'h8001ABCD, 32'hFFFFABCD, 32'h8001ABCD};
        v[7]  = '{"lbu202",  0, 1, 0, 32'h202, 0, F3_LBU, 32'h80FF7F01, 32'h000000FF, 32'h80FF7F01};
        v[8]  = '{"f3_3",    0, 1, 0, 32'h201, 0, 3'd3,   32'h8001ABCD, 32'h8001ABCD, 32'h8001ABCD};
        v[9]  = '{"f3_6",    0, 1, 0, 32'h203, 0, 3'd6,   32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
        v[10] = '{"fetch44", 1, 0, 0, 32'h44,  0, F3_LW,  32'h12345678, 32'h12345678, 32'h12345678};
        v[11] = '{"store40", 0, 1, 1, 32'h40, 32'hDEADBEEF, F3_LW, 32'h55555555, 32'h0, 32'h0};
        idle();
        bus.if_addr = 32'h0;
        bus.mem_addr = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_funct3 = 3'd0;
        bus.ram_rdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        ph = 1'b0;
        #1;
        chk("rst inst_out", bus.inst_out, 32'h0);
        chk("rst load_data", bus.load_data, 32'h0);
        chk("rst valids", {30'd0, bus.inst_valid, bus.load_valid}, 32'h0);
        chk("rst ram_we", {31'd0, bus.ram_we}, 32'h0);
        chk("rst ram_addr", bus.ram_addr, 32'h0);
        chk("rst slots", {30'd0, bus.if_slot, bus.mem_slot}, 32'h1);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h10;
        bus.ram_rdata = 32'h00500093;
        #1;
        chk("hold ph0 ram_addr", bus.ram_addr, 32'h0);
        step();
        chk("hold ph1 ram_addr", bus.ram_addr, 32'h10);
        step();
        chk("hold ph0b ram_addr", bus.ram_addr, 32'h0);
        chk("hold inst_valid", {31'd0, bus.inst_valid}, 32'h1);
        chk("hold inst_out", bus.inst_out, 32'h00500093);
        idle();
        step();
        bus.ram_rdata = 32'hFFFFFFFF;
        #1;
        chk("hold after inst_valid", {31'd0, bus.inst_valid}, 32'h0);
        chk("hold after inst_out", bus.inst_out, 32'h00500093);
        foreach (v[i]) apply(v[i]);
        while (ph != 1'b0) step();
        bus.mem_rd = 1'b1;
        bus.mem_addr = 32'h200;
        bus.mem_funct3 = F3_LW;
        step();
        bus.mem_rd = 1'b0;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h80;
        bus.ram_rdata = 32'hAAAA5555;
        #1;
        chk("b2b T1 load_valid", {31'd0, bus.load_valid}, 32'h1);
        chk("b2b T1 load_data", bus.load_data, 32'hAAAA5555);
        chk("b2b T1 inst_valid", {31'd0, bus.inst_valid}, 32'h0);
        chk("b2b T1 ram_addr", bus.ram_addr, 32'h80);
        step();
        bus.if_req = 1'b0;
        bus.ram_rdata = 32'h0BADF00D;
        #1;
        chk("b2b T2 inst_valid", {31'd0, bus.inst_valid}, 32'h1);
        chk("b2b T2 inst_out", bus.inst_out, 32'h0BADF00D);
        chk("b2b T2 load_valid", {31'd0, bus.load_valid}, 32'h0);
        step();
        bus.ram_rdata = 32'h11111111;
        #1;
        chk("b2b T3 valids", {30'd0, bus.inst_valid, bus.load_valid}, 32'h0);
        chk("b2b T3 inst_out", bus.inst_out, 32'h0BADF00D);
        chk("b2b T3 load_data", bus.load_data, 32'hAAAA5555);
        while (ph != 1'b1) step();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h90;
        step();
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.ram_rdata = 32'h77777777;
        #1;
        chk("rstpend inst_valid", {31'd0, bus.inst_valid}, 32'h0);
        step();
        rst = 1'b0;
        ph = 1'b0;
        #1;
        chk("rstpend after inst_valid", {31'd0, bus.inst_valid}, 32'h0);
        chk("rstpend inst_out", bus.inst_out, 32'h0);
        chk("rstpend load_data", bus.load_data, 32'h0);
        chk("rstpend phase", {31'd0, bus.if_slot}, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
